// File: rtl/shared_bus_arb_pkg.sv
// Shared definitions for the shared-bus round-robin arbiter:
// FSM state encoding, default bus widths and a width helper.
package shared_bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_t;

   // Widths of the tristate data/address drivers fed by the grant bits.
   localparam int DATA_W = 32;
   localparam int ADDR_W = 22;

   // Bits needed to index n items, never less than one.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request searching
// rr_ptr+1, rr_ptr+2, ... modulo N.
module rr_priority_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] rr_ptr,
   output logic         found,
   output logic [W-1:0] winner
);

   // Scan all N positions after the pointer and keep the first hit.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(rr_ptr) + i) % N;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = W'(idx);
         end
      end
   end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for the shared tristate data/address bus. Produces
// registered one-hot drive enables with dead turnaround cycles between owners.
// Optional feature: define SHARED_BUS_ARB_TIMEOUT_EN to force release of an
// owner that has held the bus MAX_HOLD cycles while others are waiting.
module shared_bus_arbiter
   import shared_bus_arb_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   parameter  int TURN_CYCLES = 1,
   parameter  int MAX_HOLD    = 16,
   localparam int OWNER_W     = clog2_min1(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [OWNER_W-1:0]     owner_id,
   output logic                   bus_idle,
   output logic                   preempt
);

   localparam int TURN_W = clog2_min1(TURN_CYCLES);

   arb_state_t             state, state_n;
   logic [NUM_MASTERS-1:0] gnt_n;
   logic [OWNER_W-1:0]     owner_n;
   logic [OWNER_W-1:0]     rr_ptr, rr_ptr_n;
   logic [TURN_W-1:0]      turn_cnt, turn_cnt_n;
   logic                   preempt_n;
   logic                   grant_now;
   logic                   found;
   logic [OWNER_W-1:0]     winner;
   logic                   owner_req;
   logic                   timeout_hit;

   rr_priority_pick #(
      .N (NUM_MASTERS),
      .W (OWNER_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   // While granted, gnt is the owner's one-hot, so masking req with it isolates the owner.
   assign owner_req = |(req & gnt);

`ifdef SHARED_BUS_ARB_TIMEOUT_EN
   localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_cnt;

   // Saturation only caps the counter; a long lone hold stays preemptible.
   assign timeout_hit = (hold_cnt >= HOLD_W'(MAX_HOLD - 1)) && |(req & ~gnt);

   // Count grant cycles of the current owner; clear when a new grant is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hold_cnt <= '0;
      else if (grant_now)
         hold_cnt <= '0;
      else if (state == ST_GRANT && hold_cnt != HOLD_W'(MAX_HOLD))
         hold_cnt <= hold_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE/GRANT/TURN controller.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      state_n    = state;
      gnt_n      = gnt;
      owner_n    = owner_id;
      rr_ptr_n   = rr_ptr;
      turn_cnt_n = turn_cnt;
      preempt_n  = 1'b0;
      grant_now  = 1'b0;
      case (state)
         ST_IDLE: grant_now = found;
         ST_GRANT: begin
            if (!owner_req || timeout_hit) begin
               state_n    = ST_TURN;
               gnt_n      = '0;
               turn_cnt_n = TURN_W'(TURN_CYCLES - 1);
               preempt_n  = owner_req;
            end
         end
         ST_TURN: begin
            if (turn_cnt == '0) begin
               if (found) grant_now = 1'b1;
               else       state_n   = ST_IDLE;
            end else begin
               turn_cnt_n = turn_cnt - 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (grant_now) begin
         state_n  = ST_GRANT;
         gnt_n    = NUM_MASTERS'(1) << winner;
         owner_n  = winner;
         rr_ptr_n = winner;
      end
   end

   // State and output registers; reset leaves master 0 with first priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         owner_id <= '0;
         rr_ptr   <= OWNER_W'(NUM_MASTERS - 1);
         turn_cnt <= '0;
         bus_idle <= 1'b1;
         preempt  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state    <= state_n;
         gnt      <= gnt_n;
         owner_id <= owner_n;
         rr_ptr   <= rr_ptr_n;
         turn_cnt <= turn_cnt_n;
         bus_idle <= ~|gnt_n;
         preempt  <= preempt_n;
      end
   end

   // Two masters driving the bus at once would be electrical contention.
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Testbench for shared_bus_arbiter (NUM_MASTERS=4). Directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
// Honours SHARED_BUS_ARB_TIMEOUT_EN the same way as the design.
module tb_shared_bus_arbiter;

   localparam int N        = 4;
   localparam int TURN     = 1;
   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] gnt, gnt3;
   logic [1:0] owner_id, owner_id3;
   logic       bus_idle, bus_idle3;
   logic       preempt, preempt3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shared_bus_arbiter #(.NUM_MASTERS(N), .TURN_CYCLES(TURN), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt),
      .owner_id(owner_id), .bus_idle(bus_idle), .preempt(preempt)
   );

   shared_bus_arbiter #(.NUM_MASTERS(N), .TURN_CYCLES(3), .MAX_HOLD(MAX_HOLD)) dut3 (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt3),
      .owner_id(owner_id3), .bus_idle(bus_idle3), .preempt(preempt3)
   );

   // Behavioural model: who owns the bus, who owned it last, how many dead
   // cycles remain, and how long the current owner has held the bus.
   typedef struct packed {
      int owner;   // -1 when nobody owns the bus
      int last;
      int dead;    // remaining dead cycles including the current one
      int held;    // grant cycles seen so far including the current one
      bit pre;
   } model_t;

   model_t m;

   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic model_t model_step(input model_t s, input logic [3:0] r);
      model_t n;
      int     w;
      n     = s;
      n.pre = 1'b0;
      if (s.owner >= 0) begin
         if (!r[s.owner]) begin
            n.owner = -1;
            n.dead  = TURN;
         end
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
         else if (s.held >= MAX_HOLD && (r & ~(4'b0001 << s.owner)) != 4'b0000) begin
            n.owner = -1;
            n.dead  = TURN;
            n.pre   = 1'b1;
         end
`endif
         else begin
            n.held = s.held + 1;
         end
      end else if (s.dead > 1) begin
         n.dead = s.dead - 1;
      end else begin
         w      = pick(r, s.last);
         n.dead = 0;
         if (w >= 0) begin
            n.owner = w;
            n.last  = w;
            n.held  = 1;
         end
      end
      return n;
   endfunction

   // Advance the model on the same edges the design uses.
   always @(posedge clk or posedge reset) begin
      if (reset) m <= '{owner: -1, last: N - 1, dead: 0, held: 0, pre: 1'b0};
      else       m <= model_step(m, req);
   end

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic go_idle();
      req = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
      total++; if (bus_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", bus_idle); end
      total++; if (preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt: got %b want 0", preempt); end
      reset = 1'b0;
      req   = 4'b0010;
      @(negedge clk);
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL pre_reset_gnt: got %b want 0010", gnt); end
      #2 reset = 1'b1;
      #1;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL async_reset_gnt: got %b want 0000", gnt); end
      total++; if (bus_idle !== 1'b1) begin bad++; $display("FAIL async_reset_idle: got %b want 1", bus_idle); end
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b0001;
      @(negedge clk);
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL post_reset_gnt: got %b want 0001", gnt); end
      total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL post_reset_owner: got %0d want 0", owner_id); end
      go_idle();
   endtask

   task automatic test_single();
      req = 4'b0100;
      @(negedge clk);
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
      total++; if (owner_id !== 2'd2) begin bad++; $display("FAIL single_owner: got %0d want 2", owner_id); end
      total++; if (bus_idle !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus_idle); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_hold%0d: got %b want 0100", c, gnt); end
      end
      req = 4'b0000;
      @(negedge clk);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", gnt); end
      total++; if (bus_idle !== 1'b1) begin bad++; $display("FAIL single_release_idle: got %b want 1", bus_idle); end
      go_idle();
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111;
      foreach (order[k]) begin
         logic [3:0] exp_g;
         exp_g = 4'b0001 << order[k];
         for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_slot%0d_hold%0d: got %b want %b", k, h, gnt, exp_g); end
         end
         req = 4'b1111 & ~exp_g;
         @(negedge clk);
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_turn%0d: got %b want 0000", k, gnt); end
         req = 4'b1111;
      end
      go_idle();
   endtask

   task automatic test_turnaround();
      do_reset();
      req = 4'b1010;
      @(negedge clk);
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ta_owner1: got %b want 0010", gnt); end
      total++; if (gnt3 !== 4'b0010) begin bad++; $display("FAIL ta3_owner1: got %b want 0010", gnt3); end
      req = 4'b1000;
      @(negedge clk);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ta_n1: got %b want 0000", gnt); end
      total++; if (gnt3 !== 4'b0000) begin bad++; $display("FAIL ta3_n1: got %b want 0000", gnt3); end
      @(negedge clk);
      total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL ta_n2: got %b want 1000", gnt); end
      total++; if (gnt3 !== 4'b0000) begin bad++; $display("FAIL ta3_n2: got %b want 0000", gnt3); end
      @(negedge clk);
      total++; if (gnt3 !== 4'b0000) begin bad++; $display("FAIL ta3_n3: got %b want 0000", gnt3); end
      @(negedge clk);
      total++; if (gnt3 !== 4'b1000) begin bad++; $display("FAIL ta3_n4: got %b want 1000", gnt3); end
      go_idle();
   endtask

   task automatic test_rerequest();
      do_reset();
      req = 4'b0001;
      @(negedge clk);
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rereq_first: got %b want 0001", gnt); end
      req = 4'b0000;
      @(negedge clk);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rereq_turn: got %b want 0000", gnt); end
      req = 4'b0011;
      @(negedge clk);
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rereq_gnt: got %b want 0010", gnt); end
      total++; if (owner_id !== 2'd1) begin bad++; $display("FAIL rereq_owner: got %0d want 1", owner_id); end
      go_idle();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0001;
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
      for (int c = 1; c <= MAX_HOLD; c++) begin
         @(negedge clk);
         total++; if ({gnt, preempt} !== {4'b0001, 1'b0}) begin bad++; $display("FAIL to_hold%0d: got %b/%b want 0001/0", c, gnt, preempt); end
         if (c == 2) req = 4'b0101;
      end
      @(negedge clk);
      total++; if ({gnt, preempt} !== {4'b0000, 1'b1}) begin bad++; $display("FAIL to_preempt: got %b/%b want 0000/1", gnt, preempt); end
      @(negedge clk);
      total++; if ({gnt, preempt} !== {4'b0100, 1'b0}) begin bad++; $display("FAIL to_next: got %b/%b want 0100/0", gnt, preempt); end
`else
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         total++; if ({gnt, preempt} !== {4'b0001, 1'b0}) begin bad++; $display("FAIL hold_%0d: got %b/%b want 0001/0", c, gnt, preempt); end
         if (c == 2) req = 4'b0101;
      end
`endif
      go_idle();
   endtask

   task automatic test_random();
      logic [3:0] exp_g;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req = req ^ 4'($urandom & $urandom);
         @(negedge clk);
         exp_g = (m.owner >= 0) ? 4'(4'b0001 << m.owner) : 4'b0000;
         total++; if (gnt !== exp_g) begin bad++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, exp_g); end
         total++; if (bus_idle !== (m.owner < 0)) begin bad++; $display("FAIL rand_idle c%0d: got %b want %b", c, bus_idle, (m.owner < 0)); end
         total++; if (preempt !== m.pre) begin bad++; $display("FAIL rand_preempt c%0d: got %b want %b", c, preempt, m.pre); end
         if (m.owner >= 0) begin
            total++; if (owner_id !== 2'(m.owner)) begin bad++; $display("FAIL rand_owner c%0d: got %0d want %0d", c, owner_id, m.owner); end
         end
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_turnaround();
      test_rerequest();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Upper bound on run time in case the design stalls a wait.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
